// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use and branch stall sequencer for the 5-stage RV32 pipe.
// Holds PC and IF/ID, bubbles ID/EX, and counts stalled cycles.
module hazard_stall_ctrl #(
   parameter int              AW     = 5,
   parameter int              OPW    = 7,
   parameter logic [OPW-1:0]  BR_OP  = OPW'(7'b1100011),
   parameter int              JMP_EN = 0,
   parameter int              LU_CYC = 1,
   parameter int              BR_CYC = 2,
   parameter int              PERF_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [OPW-1:0]    op_D,
   input  logic [AW-1:0]     rs1_D,
   input  logic [AW-1:0]     rs2_D,
   input  logic              rs1_used_D,
   input  logic              rs2_used_D,
   input  logic [AW-1:0]     rd_E,
   input  logic              reg_write_E,
   input  logic              mem_read_E,
   input  logic              ext_stall,
   input  logic              redirect,
   output logic              stall_F,
   output logic              stall_D,
   output logic              flush_E,
   output logic              busy,
   output logic [1:0]        stall_cause,
   output logic [PERF_W-1:0] stall_cycles
);

   localparam logic [OPW-1:0] JAL_OP  = OPW'(7'b1101111);
   localparam logic [OPW-1:0] JALR_OP = OPW'(7'b1100111);
   localparam logic [2:0]     LU_N    = 3'(LU_CYC);
   localparam logic [2:0]     BR_N    = 3'(BR_CYC);
   localparam logic [2:0]     MAX_N   = (LU_CYC > BR_CYC) ? LU_N : BR_N;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_STALL   = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [1:0]          cause_q, cause_d;
   logic [PERF_W-1:0]   perf_q, perf_d;

   logic                lu_hz;
   logic                br_hz;
   logic                jmp_hit;
   logic                rs1_hit;
   logic                rs2_hit;
   logic [2:0]          n_len;
   logic                hold;
   logic                bubble;

   // Hazard detection: register match for load-use, opcode decode for control flow
   always_comb begin
      rs1_hit = rs1_used_D && (rs1_D == rd_E);
      rs2_hit = rs2_used_D && (rs2_D == rd_E);
      lu_hz   = mem_read_E && reg_write_E && (rd_E != '0)
                && (rs1_hit || rs2_hit);
      jmp_hit = (JMP_EN != 0)
                && ((op_D == JAL_OP) || (op_D == JALR_OP));
      br_hz   = (op_D == BR_OP) || jmp_hit;
   end

   // Stall length for the detected hazard class; both classes take the longer one
   always_comb begin
      n_len = 3'd1;
      case ({br_hz, lu_hz})
         2'b01:   n_len = LU_N;
         2'b10:   n_len = BR_N;
         2'b11:   n_len = MAX_N;
         default: n_len = 3'd1;
      endcase
   end

   // FSM next state and stall outputs; redirect beats freeze beats sequencing
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      hold    = 1'b0;
      bubble  = 1'b0;
      if (redirect) begin
         state_d = S_IDLE;
         cnt_d   = 3'd0;
      end else if (ext_stall) begin
         hold = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (lu_hz || br_hz) begin
                  hold    = 1'b1;
                  bubble  = 1'b1;
                  cause_d = {br_hz, lu_hz};
                  if (n_len == 3'd1) begin
                     state_d = S_RELEASE;
                  end else begin
                     state_d = S_STALL;
                     cnt_d   = n_len - 3'd2;
                  end
               end
            end
            S_STALL: begin
               hold   = 1'b1;
               bubble = 1'b1;
               if (cnt_q == 3'd0) begin
                  state_d = S_RELEASE;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
            S_RELEASE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = 3'd0;
            end
         endcase
      end
   end

   // Saturating count of cycles in which IF/ID is held
   always_comb begin
      perf_d = perf_q;
      if (hold && (perf_q != '1)) begin
         perf_d = perf_q + 1'b1;
      end
   end

   // State, counter, cause and perf registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         cause_q <= 2'd0;
         perf_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
         perf_q  <= perf_d;
      end
   end

   assign stall_F      = hold && !rst;
   assign stall_D      = hold && !rst;
   assign flush_E      = bubble && !rst;
   assign busy         = (state_q != S_IDLE);
   assign stall_cause  = cause_q;
   assign stall_cycles = perf_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: vector table, corner sequences and random run
// checked against a remaining-cycles reference model.
module tb_hazard_stall_ctrl;

   localparam int AW = 5;
   localparam int OPW = 7;
   localparam int LU = 1;
   localparam int BR = 3;
   localparam int PW = 6;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_ALU  = 7'b0110011;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic [6:0]     op_D;
   logic [4:0]     rs1_D, rs2_D, rd_E;
   logic           rs1_used_D, rs2_used_D;
   logic           reg_write_E, mem_read_E;
   logic           ext_stall, redirect;
   logic           stall_F, stall_D, flush_E, busy;
   logic [1:0]     stall_cause;
   logic [PW-1:0]  stall_cycles;

   hazard_stall_ctrl #(
      .AW(AW), .OPW(OPW), .BR_OP(OP_BR), .JMP_EN(1),
      .LU_CYC(LU), .BR_CYC(BR), .PERF_W(PW)
   ) dut (
      .clk(clk), .rst(rst), .op_D(op_D),
      .rs1_D(rs1_D), .rs2_D(rs2_D),
      .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
      .rd_E(rd_E), .reg_write_E(reg_write_E), .mem_read_E(mem_read_E),
      .ext_stall(ext_stall), .redirect(redirect),
      .stall_F(stall_F), .stall_D(stall_D), .flush_E(flush_E),
      .busy(busy), .stall_cause(stall_cause), .stall_cycles(stall_cycles)
   );

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   int         m_rem = 0;
   bit         m_rel = 1'b0;
   logic [1:0] m_cause = 2'd0;
   int         m_perf = 0;

   logic       o_sf, o_sd, o_fe, o_busy;
   logic [1:0] o_cause;
   logic [PW-1:0] o_perf;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
      end
   endtask

   task automatic tick();
      logic lu, br, e_st, e_fe, e_busy;
      int n;
      @(negedge clk);
      lu = mem_read_E && reg_write_E && (rd_E != 0)
           && ((rs1_used_D && rs1_D == rd_E) || (rs2_used_D && rs2_D == rd_E));
      br = (op_D == OP_BR) || (op_D == OP_JAL) || (op_D == OP_JALR);
      n = (lu && br) ? ((LU > BR) ? LU : BR) : (lu ? LU : BR);
      e_busy = (m_rem > 0) || m_rel;
      e_st = 1'b0;
      e_fe = 1'b0;
      if (rst || redirect) begin
         e_st = 1'b0;
      end else if (ext_stall) begin
         e_st = 1'b1;
      end else if (m_rem > 0) begin
         e_st = 1'b1; e_fe = 1'b1;
      end else if (m_rel) begin
         e_st = 1'b0;
      end else if (lu || br) begin
         e_st = 1'b1; e_fe = 1'b1;
      end
      o_sf = stall_F; o_sd = stall_D; o_fe = flush_E;
      o_busy = busy; o_cause = stall_cause; o_perf = stall_cycles;
      if (chk_en) begin
         chk("stall_F", o_sf, e_st);
         chk("stall_D", o_sd, e_st);
         chk("flush_E", o_fe, e_fe);
         chk("busy", o_busy, e_busy);
         chk("cause", o_cause, m_cause);
         chk("perf", o_perf, m_perf);
      end
      @(posedge clk);
      if (rst) begin
         m_rem = 0; m_rel = 1'b0; m_cause = 2'd0; m_perf = 0;
      end else begin
         if (e_st && m_perf < (2**PW - 1)) m_perf++;
         if (redirect) begin
            m_rem = 0; m_rel = 1'b0;
         end else if (ext_stall) begin
            m_rem = m_rem;
         end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_rel = 1'b1;
         end else if (m_rel) begin
            m_rel = 1'b0;
         end else if (lu || br) begin
            m_rem = n - 1;
            m_rel = (n == 1);
            m_cause = {br, lu};
         end
      end
      #1;
   endtask

   task automatic quiet();
      op_D = OP_ALU; rs1_D = 5'd1; rs2_D = 5'd2;
      rs1_used_D = 1'b0; rs2_used_D = 1'b0;
      rd_E = 5'd0; reg_write_E = 1'b0; mem_read_E = 1'b0;
      ext_stall = 1'b0; redirect = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      logic [6:0] op;
      logic [4:0] rs1, rs2;
      logic       u1, u2;
      logic [4:0] rd;
      logic       rw, mr;
      int         n;
      logic [1:0] cause;
   } vec_t;

   vec_t tv[11];

   initial begin
      int cnt;
      logic [7:0] pat;
      tv[0]  = '{OP_ALU,  5'd5, 5'd2, 1, 1, 5'd5, 1, 1, 1, 2'd1};
      tv[1]  = '{OP_ALU,  5'd0, 5'd2, 1, 1, 5'd0, 1, 1, 0, 2'd0};
      tv[2]  = '{OP_ALU,  5'd3, 5'd5, 1, 0, 5'd5, 1, 1, 0, 2'd0};
      tv[3]  = '{OP_ALU,  5'd3, 5'd5, 1, 1, 5'd5, 1, 1, 1, 2'd1};
      tv[4]  = '{OP_ALU,  5'd5, 5'd2, 1, 1, 5'd5, 1, 0, 0, 2'd0};
      tv[5]  = '{OP_ALU,  5'd5, 5'd2, 1, 1, 5'd5, 0, 1, 0, 2'd0};
      tv[6]  = '{OP_BR,   5'd1, 5'd2, 1, 1, 5'd7, 1, 1, 3, 2'd2};
      tv[7]  = '{OP_BR,   5'd7, 5'd2, 1, 1, 5'd7, 1, 1, 3, 2'd3};
      tv[8]  = '{OP_JAL,  5'd1, 5'd2, 0, 0, 5'd7, 1, 1, 3, 2'd2};
      tv[9]  = '{OP_JALR, 5'd1, 5'd2, 1, 0, 5'd7, 1, 1, 3, 2'd2};
      tv[10] = '{OP_ALU,  5'd5, 5'd2, 1, 1, 5'd6, 1, 1, 0, 2'd0};

      quiet();
      do_reset();
      chk_en = 1'b1;
      do_reset();

      for (int v = 0; v < 11; v++) begin
         do_reset();
         op_D = tv[v].op; rs1_D = tv[v].rs1; rs2_D = tv[v].rs2;
         rs1_used_D = tv[v].u1; rs2_used_D = tv[v].u2;
         rd_E = tv[v].rd; reg_write_E = tv[v].rw; mem_read_E = tv[v].mr;
         cnt = 0;
         tick();
         if (o_sd) cnt++;
         quiet();
         for (int k = 0; k < 10; k++) begin
            tick();
            if (!o_sd) break;
            cnt++;
         end
         chk("vec_len", cnt, tv[v].n);
         chk("vec_cause", o_cause, tv[v].cause);
         chk("vec_perf", o_perf, tv[v].n);
      end

      do_reset();
      op_D = OP_BR;
      tick();
      cnt = o_sd ? 1 : 0;
      quiet();
      ext_stall = 1'b1;
      tick();
      chk("frz_flush", o_fe, 0);
      chk("frz_stall", o_sd, 1);
      if (o_sd) cnt++;
      tick();
      if (o_sd) cnt++;
      ext_stall = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (!o_sd) break;
         cnt++;
      end
      chk("frz_len", cnt, 5);
      chk("frz_perf", o_perf, 5);

      do_reset();
      op_D = OP_BR;
      tick();
      quiet();
      redirect = 1'b1;
      tick();
      chk("redir_sd", o_sd, 0);
      chk("redir_fe", o_fe, 0);
      redirect = 1'b0;
      tick();
      chk("redir_busy", o_busy, 0);
      chk("redir_cause", o_cause, 2);

      do_reset();
      op_D = OP_BR;
      tick();
      quiet();
      redirect = 1'b1;
      ext_stall = 1'b1;
      tick();
      chk("redir_ext_sf", o_sf, 0);
      quiet();
      tick();

      do_reset();
      op_D = OP_BR;
      tick();
      quiet();
      tick();
      rst = 1'b1;
      tick();
      chk("rst_sd", o_sd, 0);
      rst = 1'b0;
      tick();
      chk("rst_perf", o_perf, 0);
      chk("rst_busy", o_busy, 0);

      do_reset();
      op_D = OP_BR;
      pat = 8'd0;
      for (int k = 0; k < 8; k++) begin
         tick();
         pat = {pat[6:0], o_sd};
      end
      chk("b2b_pattern", pat, 8'b11101110);
      quiet();

      do_reset();
      ext_stall = 1'b1;
      for (int k = 0; k < 70; k++) tick();
      ext_stall = 1'b0;
      tick();
      chk("sat_perf", o_perf, 63);

      do_reset();
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 99) == 0);
         redirect = ($urandom_range(0, 99) < 5);
         ext_stall = ($urandom_range(0, 99) < 12);
         case ($urandom_range(0, 5))
            0: op_D = OP_BR;
            1: op_D = OP_JAL;
            2: op_D = OP_JALR;
            default: op_D = OP_ALU;
         endcase
         rs1_D = 5'($urandom_range(0, 3));
         rs2_D = 5'($urandom_range(0, 3));
         rd_E = 5'($urandom_range(0, 3));
         rs1_used_D = 1'($urandom);
         rs2_used_D = 1'($urandom);
         reg_write_E = 1'($urandom);
         mem_read_E = 1'($urandom);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Parametrised stall controller for the 5-stage RV32 pipeline.
- Detects load-use hazards by register comparison, not a blanket stall on any EX load.
- Detects branch/jump control hazards in ID.
- Stalls IF/ID for a configurable number of cycles per hazard class and injects bubbles into EX.
- Sits between the ID/EX pipeline registers and the PC/IF-ID enables. Adds external-freeze and redirect-abort handling, plus a stall performance counter.

Parameters:
AW, 5, register address width
OPW, 7, opcode width
BR_OP, 7'b1100011, opcode treated as conditional branch
JMP_EN, 0, 1 = JAL (7'b1101111) and JALR (7'b1100111) also take the branch stall
LU_CYC, 1, load-use stall length in cycles (1..7)
BR_CYC, 2, branch/jump stall length in cycles (1..7)
PERF_W, 16, stall performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
op_D  in  OPW  opcode of instruction in ID
rs1_D, rs2_D  in  AW each  ID source registers
rs1_used_D, rs2_used_D  in  1 each  source actually read by ID instruction
rd_E  in  AW  EX destination register
reg_write_E  in  1  EX writes register file
mem_read_E  in  1  EX is a load
ext_stall  in  1  whole-pipe freeze (e.g. memory not ready)
redirect  in  1  branch resolved taken/mispredicted; aborts pending stall
stall_F  out  1  hold PC
stall_D  out  1  hold IF/ID register
flush_E  out  1  bubble into ID/EX register
busy  out  1  FSM not IDLE
stall_cause  out  2  registered cause of current/last stall: 0 none, 1 load-use, 2 branch, 3 both
stall_cycles  out  PERF_W  saturating count of cycles with stall_D=1

Behaviour:
- Reset is synchronous: state=IDLE, cnt=0, stall_cause=0, stall_cycles=0. While rst=1, stall_F=stall_D=flush_E=0.
- Load-use hazard (lu_hz), combinational: mem_read_E & reg_write_E & (rd_E!=0) & ((rs1_used_D & rs1_D==rd_E) | (rs2_used_D & rs2_D==rd_E)).
- Branch hazard (br_hz): op_D==BR_OP, or JMP_EN & op_D is JAL/JALR.
- Hazard length N = LU_CYC if only lu_hz; BR_CYC if only br_hz; max(LU_CYC,BR_CYC) if both.
- FSM states:
  - IDLE: detection enabled. On lu_hz|br_hz, stall_F=stall_D=flush_E=1 in that same cycle (cycle 1 of N), and stall_cause is latched. Next state is RELEASE if N==1, else STALL with cnt=N-2.
  - STALL: stall_F=stall_D=flush_E=1. If cnt==0, go to RELEASE; else decrement cnt.
  - RELEASE: exactly one cycle. Outputs are 0 and detection is masked, so the held instruction advances without re-triggering. Next state is IDLE.
- Total stall cycles per hazard is exactly N. Back-to-back hazardous instructions are each served; the next instruction is evaluated in the IDLE cycle after RELEASE.
- ext_stall=1:
  - stall_F=stall_D=1 and flush_E=0.
  - State and cnt are frozen, and IDLE performs no new detection.
  - stall_cycles increments.
  - When ext_stall deasserts, the FSM resumes exactly where it was.
- redirect=1 has priority over everything except rst:
  - stall_F=stall_D=flush_E=0 in that cycle.
  - Next state is IDLE with cnt=0. stall_cause is retained.
- redirect and ext_stall together: redirect wins.
- stall_cycles increments every cycle with stall_D=1 and saturates at all-ones, with no wrap.
- busy = (state!=IDLE).
- No outputs are registered except busy, stall_cause and stall_cycles. Stall outputs are combinational from state and inputs, so the hazard is covered in the detection cycle.

Test Plan:
- lw x5 in EX (mem_read_E=1, rd_E=5), ID add with rs1_D=5, rs1_used_D=1, LU_CYC=1 -> stall_D=flush_E=1 for 1 cycle, then RELEASE with outputs 0; stall_cause=1, stall_cycles=1.
- Same but rd_E=0, or rs2_D=5 with rs2_used_D=0 -> no stall; busy stays 0.
- op_D=7'b1100011, BR_CYC=2 -> stall_D high exactly 2 cycles, RELEASE 1 cycle, IDLE; stall_cause=2. With BR_CYC=4 -> 4 cycles.
- Load-use plus branch in ID together, LU_CYC=1, BR_CYC=3 -> 3 stall cycles; stall_cause=3.
- Branch stall BR_CYC=3, ext_stall high for 2 cycles after cycle 1 -> flush_E=0 during the freeze; total stall_D-high cycles = 5; stall_cycles=5.
- Mid-stall redirect at cycle 2 of BR_CYC=4 -> outputs 0 that cycle; next cycle IDLE with busy=0. Mid-stall rst -> all outputs and counter 0 next cycle.
